// File: rtl/pipelined_add_sub.sv
// Ripple-segmented adder/subtractor: each stage resolves SEG bits and hands
// its carry, the untouched upper operand bits and the finished low sum bits on.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int SEG = (STAGES >= 1) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    logic advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added; the current segment sits at the bottom.
        localparam int RW = WIDTH - k * SEG;

        logic [RW-1:0]          a_in;
        logic [RW-1:0]          b_in;
        logic                   c_in;
        logic                   v_in;
        logic [SEG:0]           seg_sum;
        logic [(k+1)*SEG-1:0]   s_nxt;
        logic [(k+1)*SEG-1:0]   s_q;
        logic                   c_q;
        logic                   v_q;

        if (k == 0) begin : g_src
            // Subtract is folded into the operands once, at capture.
            assign a_in  = A;
            assign b_in  = Sub ? ~B : B;
            assign c_in  = Sub | Cin;
            assign v_in  = in_valid;
            assign s_nxt = seg_sum[SEG-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign s_nxt = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
        end

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + (SEG+1)'(c_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                c_q <= seg_sum[SEG];
                s_q <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-SEG-1:0] a_q;
            logic [RW-SEG-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[RW-1:SEG];
                    b_q <= b_in[RW-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB's own sum bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign Sum       = g_stage[STAGES-1].s_q;
    assign Cout      = g_stage[STAGES-1].c_q;
    assign Overflow  = g_stage[STAGES-1].g_last.ovf_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

endmodule
